// File: rtl/mod_arbiter.sv
// Round-robin front end that shares one serial 32-bit mod unit among N_REQ requesters,
// with a divide-by-zero bypass and a watchdog against a missing done pulse.
module mod_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_dividend,
    input  logic [32*N_REQ-1:0]   req_divisor,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mod_gen,
    output logic [31:0]           mod_dividend,
    output logic [31:0]           mod_divisor,
    input  logic                  mod_gen_end,
    input  logic [31:0]           mod_res
);
    localparam int OW   = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              mod_gen_q, mod_gen_d;
    logic [31:0]       mod_dividend_q, mod_dividend_d;
    logic [31:0]       mod_divisor_q, mod_divisor_d;

    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic [31:0]       sel_dividend;
    logic [31:0]       sel_divisor;

    function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin pick: first asserted request at or after ptr_q, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = {OW{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && req[(int'(ptr_q) + k) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = OW'((int'(ptr_q) + k) % N_REQ);
            end else begin
                pick_found = pick_found;
            end
        end
    end

    assign sel_dividend = req_dividend[32*int'(pick_idx) +: 32];
    assign sel_divisor  = req_divisor[32*int'(pick_idx) +: 32];

    // Next-state and next-output logic; outputs are computed one state ahead so they register cleanly.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        wd_d           = wd_q;
        gnt_d          = {N_REQ{1'b0}};
        rsp_valid_d    = {N_REQ{1'b0}};
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        mod_gen_d      = 1'b0;
        mod_dividend_d = mod_dividend_q;
        mod_divisor_d  = mod_divisor_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    owner_d        = pick_idx;
                    mod_dividend_d = sel_dividend;
                    mod_divisor_d  = sel_divisor;
                    gnt_d          = onehot(pick_idx);
                    if (sel_divisor != 32'd0) begin
                        state_d   = S_ISSUE;
                        mod_gen_d = 1'b1;
                    end else begin
                        // Divide-by-zero answers immediately and never starts the unit.
                        state_d     = S_RESP;
                        rsp_valid_d = onehot(pick_idx);
                        rsp_data_d  = sel_dividend;
                        rsp_err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wd_d    = {WD_W{1'b0}};
            end
            S_WAIT: begin
                if (wd_q != WD_LAST) begin
                    wd_d = wd_q + WD_W'(1);
                end else begin
                    wd_d = wd_q;
                end
                // A done pulse in the watchdog's last cycle still counts as success.
                if (mod_gen_end) begin
                    state_d     = S_RESP;
                    rsp_valid_d = onehot(owner_q);
                    rsp_data_d  = mod_res;
                    rsp_err_d   = 1'b0;
                end else if (wd_q == WD_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = onehot(owner_q);
                    rsp_data_d  = 32'd0;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (owner_q == OW'(N_REQ - 1)) begin
                    ptr_d = {OW{1'b0}};
                end else begin
                    ptr_d = owner_q + OW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= {OW{1'b0}};
            owner_q        <= {OW{1'b0}};
            wd_q           <= {WD_W{1'b0}};
            gnt_q          <= {N_REQ{1'b0}};
            rsp_valid_q    <= {N_REQ{1'b0}};
            rsp_data_q     <= 32'd0;
            rsp_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            mod_gen_q      <= 1'b0;
            mod_dividend_q <= 32'd0;
            mod_divisor_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            wd_q           <= wd_d;
            gnt_q          <= gnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            busy_q         <= busy_d;
            mod_gen_q      <= mod_gen_d;
            mod_dividend_q <= mod_dividend_d;
            mod_divisor_q  <= mod_divisor_d;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;
    assign mod_gen      = mod_gen_q;
    assign mod_dividend = mod_dividend_q;
    assign mod_divisor  = mod_divisor_q;

endmodule

// File: tb/tb_mod_arbiter.sv
// Bench for mod_arbiter: a cycle-accurate stand-in for the mod unit, a directed vector table,
// hand-written corner sequences and randomized batches checked against a round-robin schedule model.
module tb_mod_arbiter;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [32*N-1:0]   req_dividend = '0;
    logic [32*N-1:0]   req_divisor = '0;
    logic [N-1:0]      gnt, rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err, busy, mod_gen;
    logic [31:0]       mod_dividend, mod_divisor;
    logic              mod_gen_end = 1'b0;
    logic [31:0]       mod_res = 32'd0;

    mod_arbiter #(.N_REQ(N), .TIMEOUT(48)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mod_gen(mod_gen), .mod_dividend(mod_dividend), .mod_divisor(mod_divisor),
        .mod_gen_end(mod_gen_end), .mod_res(mod_res)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   calc_cnt = 0;
    int   mg_cnt = 0;
    logic mod_stub = 1'b0;
    logic stray_req = 1'b0;
    logic rearm_en = 1'b0;

    typedef struct { int cyc; int who; } gev_t;
    typedef struct { int cyc; int who; logic [31:0] data; logic err; } rev_t;
    typedef struct { int who; logic [31:0] dvd; logic [31:0] dvs;
                     logic [31:0] exp_data; logic exp_err; int exp_rel; logic stub; } vec_t;
    typedef struct { int who; int gnt_rel; int rsp_rel; logic [31:0] data; logic err; } exp_t;

    gev_t gq[$];
    rev_t rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the mod unit: start seen at edge E1, done pulse during cycle 34.
    always @(posedge clk) begin
        mod_gen_end <= 1'b0;
        mod_res     <= 32'hA5A5_5A5A;
        if (rst) begin
            calc_cnt <= 0;
        end else begin
            if (stray_req) begin
                mod_gen_end <= 1'b1;
                mod_res     <= 32'h0BAD_0BAD;
            end
            if (calc_cnt == 32) begin
                calc_cnt <= 0;
                if (!mod_stub && mod_divisor != 32'd0) begin
                    mod_gen_end <= 1'b1;
                    mod_res     <= mod_dividend % mod_divisor;
                end
            end else if (calc_cnt != 0) begin
                calc_cnt <= calc_cnt + 1;
            end else if (mod_gen) begin
                calc_cnt <= 1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    function automatic int oh2i(input logic [N-1:0] v);
        int r = -1;
        if ($onehot(v)) begin
            for (int i = 0; i < N; i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
        end
    endtask

    // Advance to the next falling edge, log events, and play the requesters' drop/re-raise rules.
    task automatic tick();
        @(negedge clk);
        if (gnt != '0) gq.push_back('{cyc, oh2i(gnt)});
        if (rsp_valid != '0) rq.push_back('{cyc, oh2i(rsp_valid), rsp_data, rsp_err});
        if (mod_gen) mg_cnt++;
        req = req & ~gnt;
        if (rearm_en) req = req | rsp_valid;
    endtask

    task automatic set_ops(input int i, input logic [31:0] dvd, input logic [31:0] dvs);
        req_dividend[32*i +: 32] = dvd;
        req_divisor[32*i +: 32]  = dvs;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mod_gen"}, 32'(mod_gen), 32'd0);
        chk({tag, "_mod_dividend"}, mod_dividend, 32'd0);
        chk({tag, "_mod_divisor"}, mod_divisor, 32'd0);
    endtask

    initial begin
        vec_t        vecs[8];
        vec_t        v;
        exp_t        eq[$];
        exp_t        e;
        logic [31:0] a_dvd[N];
        logic [31:0] a_dvs[N];
        logic [N-1:0] mask, pend;
        int          s, t, m0, p, tg, ptr_m, j;

        vecs[0] = '{1, 32'd100,        32'd7,   32'd2,      1'b0, 35, 1'b0};
        vecs[1] = '{3, 32'd123,        32'd0,   32'd123,    1'b1, 1,  1'b0};
        vecs[2] = '{2, 32'hFFFF_FFFF,  32'd10,  32'd5,      1'b0, 35, 1'b0};
        vecs[3] = '{0, 32'd50,         32'd50,  32'd0,      1'b0, 35, 1'b0};
        vecs[4] = '{0, 32'd7,          32'd100, 32'd7,      1'b0, 35, 1'b0};
        vecs[5] = '{1, 32'h0000_DEAD,  32'd0,   32'h0000_DEAD, 1'b1, 1, 1'b0};
        vecs[6] = '{2, 32'd1000,       32'd3,   32'd0,      1'b1, 50, 1'b1};
        vecs[7] = '{2, 32'd1000,       32'd3,   32'd1,      1'b0, 35, 1'b0};

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Directed single-request table
        for (int k = 0; k < 8; k++) begin
            v = vecs[k];
            mod_stub = v.stub;
            gq.delete();
            rq.delete();
            m0 = mg_cnt;
            set_ops(v.who, v.dvd, v.dvs);
            req[v.who] = 1'b1;
            s = cyc;
            t = 0;
            while (rq.size() == 0 && t < 80) begin tick(); t++; end
            tick();
            chk($sformatf("v%0d_busy_after_rsp", k), 32'(busy), 32'd0);
            chk($sformatf("v%0d_gnt_count", k), gq.size(), 32'd1);
            if (gq.size() > 0) begin
                chk($sformatf("v%0d_gnt_who", k), gq[0].who, v.who);
                chk($sformatf("v%0d_gnt_cycle", k), gq[0].cyc - s, 32'd1);
            end
            chk($sformatf("v%0d_rsp_count", k), rq.size(), 32'd1);
            if (rq.size() > 0) begin
                chk($sformatf("v%0d_rsp_who", k), rq[0].who, v.who);
                chk($sformatf("v%0d_rsp_cycle", k), rq[0].cyc - s, v.exp_rel);
                chk($sformatf("v%0d_rsp_data", k), rq[0].data, v.exp_data);
                chk($sformatf("v%0d_rsp_err", k), 32'(rq[0].err), 32'(v.exp_err));
            end
            chk($sformatf("v%0d_mod_gen_pulses", k), mg_cnt - m0, (v.dvs != 32'd0) ? 32'd1 : 32'd0);
            mod_stub = 1'b0;
        end

        // Two simultaneous requests right after reset
        do_reset();
        gq.delete();
        rq.delete();
        set_ops(0, 32'hFFFF_FFFF, 32'd10);
        set_ops(2, 32'd50, 32'd50);
        req = 4'b0101;
        s = cyc;
        t = 0;
        while (rq.size() < 2 && t < 120) begin tick(); t++; end
        chk("simul_rsp_count", rq.size(), 32'd2);
        if (rq.size() >= 2) begin
            chk("simul_first_who", rq[0].who, 32'd0);
            chk("simul_first_cycle", rq[0].cyc - s, 32'd35);
            chk("simul_first_data", rq[0].data, 32'd5);
            chk("simul_second_who", rq[1].who, 32'd2);
            chk("simul_second_data", rq[1].data, 32'd0);
            chk("simul_spacing", rq[1].cyc - rq[0].cyc, 32'd36);
        end

        // Round-robin fairness with all four requesters re-raising after each response
        do_reset();
        gq.delete();
        rq.delete();
        for (int i = 0; i < N; i++) set_ops(i, 32'(20 + i), 32'd3);
        req = 4'b1111;
        rearm_en = 1'b1;
        t = 0;
        while (gq.size() < 5 && t < 300) begin tick(); t++; end
        rearm_en = 1'b0;
        chk("rr_grant_count", (gq.size() >= 5) ? 32'd5 : 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) chk($sformatf("rr_grant_%0d", i), gq[i].who, i % N);
        end
        t = 0;
        while ((req != '0 || busy) && t < 300) begin tick(); t++; end
        chk("rr_drained", 32'(req != '0 || busy), 32'd0);

        // Reset in the middle of WAIT, with ptr left non-zero beforehand
        gq.delete();
        rq.delete();
        set_ops(1, 32'd9, 32'd0);
        req[1] = 1'b1;
        t = 0;
        while (rq.size() == 0 && t < 10) begin tick(); t++; end
        tick();
        gq.delete();
        rq.delete();
        set_ops(1, 32'd100, 32'd7);
        req[1] = 1'b1;
        s = cyc;
        while (cyc - s < 20) tick();
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        while (cyc - s < 60) tick();
        chk("midrst_no_rsp", rq.size(), 32'd0);
        gq.delete();
        set_ops(0, 32'd10, 32'd0);
        set_ops(2, 32'd12, 32'd0);
        set_ops(3, 32'd13, 32'd0);
        req = 4'b1101;
        t = 0;
        while (gq.size() < 3 && t < 30) begin tick(); t++; end
        chk("midrst_ptr_count", gq.size(), 32'd3);
        if (gq.size() >= 3) begin
            chk("midrst_ptr_first", gq[0].who, 32'd0);
            chk("midrst_ptr_second", gq[1].who, 32'd2);
            chk("midrst_ptr_third", gq[2].who, 32'd3);
        end
        tick();
        tick();

        // Stray done pulse while idle
        rq.delete();
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stray_no_rsp", rq.size(), 32'd0);
        chk("stray_idle", 32'(busy), 32'd0);

        // Randomized batches against a round-robin schedule model
        do_reset();
        ptr_m = 0;
        for (int it = 0; it < 30; it++) begin
            mask = 4'($urandom_range(15, 1));
            for (int i = 0; i < N; i++) begin
                a_dvd[i] = $urandom;
                case ($urandom_range(3, 0))
                    0: a_dvs[i] = 32'd0;
                    1: a_dvs[i] = 32'($urandom_range(16, 1));
                    default: a_dvs[i] = $urandom;
                endcase
                set_ops(i, a_dvd[i], a_dvs[i]);
            end
            eq.delete();
            pend = mask;
            p = ptr_m;
            tg = 1;
            while (pend != '0) begin
                j = p;
                for (int k = 0; k < N; k++) begin
                    if (pend[(p + k) % N]) begin j = (p + k) % N; break; end
                end
                e.who = j;
                e.gnt_rel = tg;
                e.err = (a_dvs[j] == 32'd0);
                e.data = e.err ? a_dvd[j] : a_dvd[j] % a_dvs[j];
                e.rsp_rel = tg + (e.err ? 0 : 34);
                eq.push_back(e);
                tg = e.rsp_rel + 2;
                p = (j + 1) % N;
                pend[j] = 1'b0;
            end
            ptr_m = p;
            gq.delete();
            rq.delete();
            req = mask;
            s = cyc;
            t = 0;
            while (rq.size() < eq.size() && t < eq.size() * 40 + 20) begin tick(); t++; end
            tick();
            chk($sformatf("rnd%0d_rsp_count", it), rq.size(), eq.size());
            chk($sformatf("rnd%0d_gnt_count", it), gq.size(), eq.size());
            for (int i = 0; i < eq.size(); i++) begin
                if (i < gq.size()) begin
                    chk($sformatf("rnd%0d_gnt%0d_who", it, i), gq[i].who, eq[i].who);
                    chk($sformatf("rnd%0d_gnt%0d_cycle", it, i), gq[i].cyc - s, eq[i].gnt_rel);
                end
                if (i < rq.size()) begin
                    chk($sformatf("rnd%0d_rsp%0d_who", it, i), rq[i].who, eq[i].who);
                    chk($sformatf("rnd%0d_rsp%0d_cycle", it, i), rq[i].cyc - s, eq[i].rsp_rel);
                    chk($sformatf("rnd%0d_rsp%0d_data", it, i), rq[i].data, eq[i].data);
                    chk($sformatf("rnd%0d_rsp%0d_err", it, i), 32'(rq[i].err), 32'(eq[i].err));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mod_arbiter.md
# mod_arbiter

Round-robin arbiter and sequencer sharing one `mod` unit (32-bit remainder, 32-iteration serial datapath) among `N_REQ` requesters. It captures a request and its operands, pulses the unit's start, and waits for the unit's done pulse. It then returns the remainder, tagged one-hot, to the owning requester. Divide-by-zero is short-circuited without touching the unit, and a watchdog recovers from a missing done pulse. It sits between the requesting engines and the single `mod` instance at the datapath top level.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 48: maximum cycles spent in WAIT before an error response; must be at least 34.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high. When `mod` is instantiated alongside, the top level drives its `rstn` as `~rst`.
- `req` input N_REQ: per-requester request level.
- `req_dividend` input 32*N_REQ: packed dividends; slice i is bits [32i+31:32i].
- `req_divisor` input 32*N_REQ: packed divisors, same packing as `req_dividend`.
- `gnt` output N_REQ: one-hot, one-cycle pulse; operands of that requester were captured.
- `rsp_valid` output N_REQ: one-hot, one-cycle pulse; `rsp_data`/`rsp_err` are valid for that requester.
- `rsp_data` output 32: remainder; dividend on divide-by-zero; 0 on timeout.
- `rsp_err` output 1: 1 for divide-by-zero or timeout, qualified by `rsp_valid`.
- `busy` output 1: 1 in any state other than IDLE.
- `mod_gen` output 1: one-cycle start pulse to `mod`.
- `mod_dividend` output 32: latched operand; held stable from ISSUE through RESP.
- `mod_divisor` output 32: latched operand; held stable from ISSUE through RESP.
- `mod_gen_end` input 1: done pulse from `mod`.
- `mod_res` input 32: remainder from `mod`, valid while `mod_gen_end` is 1.

## Operation
- **State machine:** IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **Reset:** state=IDLE, `ptr`=0, owner=0, watchdog=0. All outputs are 0, including `mod_dividend`, `mod_divisor` and `rsp_data`.
- **IDLE, arbitration:** when `req` is nonzero, select the first set bit searching `ptr`, `ptr`+1, … modulo N_REQ.
  - Latch the owner index and its dividend/divisor.
  - If divisor != 0, go to ISSUE.
  - If divisor == 0, go to RESP with err=1 and data=dividend. `mod` is never started in this case.
- **ISSUE (1 cycle):** `gnt[owner]`=1 and `mod_gen`=1. Watchdog is cleared. Next state WAIT.
- **WAIT:** watchdog increments each cycle.
  - If `mod_gen_end` is 1, latch `mod_res`, set err=0, go to RESP.
  - Else if watchdog == TIMEOUT-1, set data=0, err=1, go to RESP.
- **RESP (1 cycle):** `rsp_valid[owner]`=1 with data/err. For the divide-by-zero path, `gnt[owner]` is also 1 in this same cycle. Then `ptr` = (owner+1) mod N_REQ and next state is IDLE.
- **Request sampling:** `req` is sampled only in IDLE. Requests arriving in other states wait; there is no queueing beyond the level-held `req`.
- **Requester rules:** keep `req[i]` and its operands stable until `gnt[i]`, and drop `req[i]` in the cycle after `gnt[i]`. A `req` still high when the arbiter returns to IDLE is treated as a new request.
- **Stray done pulses:** `mod_gen_end` outside WAIT is ignored.
- **Watchdog width:** the counter is clog2(TIMEOUT) bits and never wraps, since it is cleared in ISSUE.
- **Reset mid-operation:** the in-flight request is dropped with no `rsp_valid`, and `ptr` returns to 0.

## Timing
- **Normal transaction:** `req[i]` sampled at edge E0. Cycle numbers below are the cycles after that edge.

  | Cycle | Event |
  |---|---|
  | 1 | ISSUE: `gnt` and `mod_gen` |
  | 2–33 | `mod` CALC |
  | 34 | `mod_gen_end` |
  | 35 | RESP: `rsp_valid` |
  | 36 | IDLE |

- **Normal latency and throughput:** 35 cycles from sample to `rsp_valid`. The next request is sampled at the end of cycle 36, giving 36 cycles per operation.
- **Divide-by-zero:** `gnt`+`rsp_valid` in cycle 1, IDLE in cycle 2, so 2 cycles per operation.
- **Timeout:** WAIT occupies cycles 2 .. TIMEOUT+1 and RESP is cycle TIMEOUT+2. With the default, `rsp_valid`+err arrives in cycle 50.
- **Simultaneous events:**
  - `mod_gen_end` in the watchdog's final cycle counts as success.
  - `rst` asserted together with any event takes priority.

## Test plan
- **Single request:** `req[1]` with 100 % 7 → `gnt[1]` in cycle 1, `rsp_valid[1]` in cycle 35, data=2, err=0, `busy` low in cycle 36.
- **Simultaneous requests after reset:** `req`=4'b0101 with 0xFFFFFFFF % 10 and 50 % 50 → requester 0 served first (data=5), then requester 2 (data=0). `rsp_valid[2]` lands 36 cycles after `rsp_valid[0]`.
- **Round-robin fairness:** all four `req` held, re-asserted after each response → grant order 0, 1, 2, 3, 0, with no requester granted twice before the others are served.
- **Divide-by-zero:** `req[3]` with 123 % 0 → `gnt[3]` and `rsp_valid[3]` both in cycle 1, data=123, err=1, `mod_gen` never asserted.
- **Missing done:** `mod_gen_end` stubbed to 0 → `rsp_valid` in cycle 50 with data=0, err=1. A subsequent request proceeds normally.
- **Reset mid-WAIT and stray done:** `rst` pulsed in cycle 20 → no `rsp_valid`, all outputs 0 and `ptr`=0 in the following cycle. A `mod_gen_end` pulse injected while in IDLE produces no response.
